ili9341_spi_rx: RTL and testbench
=================================

# ili9341_spi_rx

Display-side receiver for the ILI9341 4-wire SPI link driven by `ili9341_top`. It oversamples `spi_sck`/`spi_cs`/`spi_mosi`/`spi_dc` on the system clock and deserialises bytes MSB-first. It decodes the CASET/PASET/RAMWR command set and emits one RGB565 pixel write, with its (x, y) cursor, per two RAMWR data bytes. It is used as a bench/on-chip monitor to check what the pet-visualisation path actually draws.

## Interface
- `COORD_W`, 9: width of x/y cursor; the 16-bit CASET/PASET parameters are truncated to their low `COORD_W` bits.
- `COLS`, 240: reset/SWRESET column window end + 1.
- `ROWS`, 320: reset/SWRESET page window end + 1.

- `clk` in 1: system clock; must be ≥ 4× SCK frequency.
- `rst` in 1: synchronous, active-high reset.
- `spi_sck` in 1: SPI clock, mode 0; data is sampled on the rising edge.
- `spi_cs` in 1: chip select, active low.
- `spi_mosi` in 1: serial data, MSB first.
- `spi_dc` in 1: 0 = command, 1 = data; sampled with bit 0.
- `byte_valid` out 1: one-cycle pulse per received byte.
- `byte_data` out 8: received byte; held until the next byte.
- `byte_dc` out 1: `dc` value of that byte.
- `pix_valid` out 1: one-cycle pixel-write pulse.
- `pix_x`, `pix_y` out COORD_W: coordinates of the pixel being written.
- `pix_data` out 16: RGB565 value, first byte = [15:8].
- `frame_start` out 1: pulse when a RAMWR command is decoded.
- `err_abort` out 1: pulse when CS rises with 1–7 bits pending.

## Operation
- **Byte layer**
  - Bit counter 0..7 advances on each detected SCK rising edge while CS is low.
  - On count 7: assemble the byte, latch dc, pulse `byte_valid`, clear the counter.
  - CS high clears the counter and shift register. If the counter was ≠0, pulse `err_abort`.
- **Decoder FSM** with states IDLE, CASET, PASET, RAMWR, SKIP.
  - A command byte (dc=0) is accepted in any state:
    - 0x2A → CASET
    - 0x2B → PASET
    - 0x2C → RAMWR, with cursor x=SC, y=SP and a `frame_start` pulse
    - 0x3C → RAMWR, with cursor unchanged
    - 0x01 → window reset to defaults, then IDLE
    - other → SKIP
  - CASET/PASET: data bytes 0..3 are SChi, SClo, EChi, EClo (PASET: SP, EP). Each pair is committed to its register when the low byte arrives. A 5th or later byte is ignored. A partially received pair is discarded when a new command arrives.
  - RAMWR:
    - Even data byte: latch the high half.
    - Odd data byte: emit a pixel, then advance the cursor:
      - if x ≥ EC: x←SC, y←y+1, and if y ≥ EP then y←SP;
      - else x←x+1.
  - SKIP/IDLE: data bytes produce `byte_valid` only.
  - CS high while in RAMWR discards a pending high half; the state and cursor are kept.
- **Defaults** (reset and SWRESET): SC=0, EC=COLS−1, SP=0, EP=ROWS−1, x=y=0, state IDLE.
- **Reset values:** every output 0; `byte_data`/`pix_*` read 0.

## Timing
- SCK/CS edges are detected 3 clk after the pin edge with sync enabled, 1 clk without.
- `byte_valid` is asserted in the cycle after the 8th edge detection.
- `pix_valid`, `pix_x/y`, `pix_data` are asserted one cycle after the odd byte's `byte_valid`. The cursor update is visible on the following pixel.
- `frame_start` coincides with the command's `byte_valid` + 1 cycle.
- If an SCK edge and a CS rise are detected in the same cycle, the CS rise wins and the bit is dropped.
- `rst` mid-byte or mid-pixel: all state clears the next cycle; no pulse is emitted.

## Configuration
- `ILI_RX_SYNC_EN` defined: each SPI input passes through a 2-flop synchroniser before edge detection (3-clk edge latency). Required for hardware.
- `ILI_RX_SYNC_EN` undefined: inputs are registered once (1-clk latency), for same-clock simulation only.

## Structure
- Shared package `ili9341_pkg`:
  - command constants CMD_CASET=0x2A, CMD_PASET=0x2B, CMD_RAMWR=0x2C, CMD_RAMWRC=0x3C, CMD_SWRESET=0x01;
  - FSM state encoding.
  - `ili9341_top` imports the same constants.
- One sub-module `spi_byte_rx`: sync, edge detect, bit counter, and the `err_abort` logic. The decoder FSM and cursor stay in the top.

## Test plan
- **Single byte:** send 0xA5 with dc=1 at SCK = clk/8 → one `byte_valid`, `byte_data`=0xA5, `byte_dc`=1.
- **Cursor wrap:** send CASET 0,10,0,11; PASET 0,5,0,6; RAMWR; 5 pixels 0xF800 → pixels at (10,5), (11,5), (10,6), (11,6), (10,5), all `pix_data`=0xF800; `frame_start` pulses once.
- **Abort:** raise CS after 3 bits → `err_abort` pulses once, no `byte_valid`; the next full byte 0x3C is decoded correctly.
- **Mid-pixel break:** in RAMWR, send a high byte, toggle CS, then send 0x12,0x34 → one pixel with `pix_data`=0x1234 at the unchanged cursor.
- **Defaults and truncation:** send SWRESET, then RAMWR with 240 pixels → last pixel at (239,0) and the next at (0,1). Then send CASET 0x02,0x05,… → SC=0x005 when COORD_W=9.
- **Reset:** assert `rst` mid-RAMWR → all outputs 0 the next cycle; data bytes are then ignored until a new command.

Source files
------------

// File: rtl/ili9341_pkg.sv
// ili9341_pkg: ILI9341 command constants and receiver decoder state encoding.
package ili9341_pkg;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  typedef enum logic [2:0] {ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR, ST_SKIP} state_t;
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: oversampling SPI mode-0 byte deserialiser with CS-abort detection.
// ILI_RX_SYNC_EN adds a 2-flop synchroniser ahead of the edge-detect register.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       cs_rise,
  output logic       err_abort
);
`ifdef ILI_RX_SYNC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif
  logic [DEPTH:0] sck_p, cs_p;
  logic [DEPTH-1:0] mosi_p, dc_p;
  logic [2:0] cnt;
  logic [6:0] sr;
  logic sck_up, cs_up, cs_low, mosi_s, dc_s;
  assign sck_up = sck_p[DEPTH-1] & ~sck_p[DEPTH];
  assign cs_up  = cs_p[DEPTH-1] & ~cs_p[DEPTH];
  assign cs_low = ~cs_p[DEPTH-1];
  assign mosi_s = mosi_p[DEPTH-1];
  assign dc_s   = dc_p[DEPTH-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_p  <= '0;
      cs_p   <= '1;
      mosi_p <= '0;
      dc_p   <= '0;
    end else begin
      sck_p  <= (DEPTH+1)'({sck_p, spi_sck});
      cs_p   <= (DEPTH+1)'({cs_p, spi_cs});
      mosi_p <= DEPTH'({mosi_p, spi_mosi});
      dc_p   <= DEPTH'({dc_p, spi_dc});
    end
  end
  // a CS-high level (and thus a CS rise) overrides any coincident SCK edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 3'd0;
      sr         <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
      cs_rise    <= 1'b0;
      err_abort  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      cs_rise    <= cs_up;
      err_abort  <= cs_up && cnt != 3'd0;
      if (!cs_low) begin
        cnt <= 3'd0;
        sr  <= 7'd0;
      end else if (sck_up) begin
        cnt <= cnt + 3'd1;
        sr  <= {sr[5:0], mosi_s};
        if (cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {sr, mosi_s};
          byte_dc    <= dc_s;
        end
      end
    end
  end
endmodule

// File: rtl/ili9341_spi_rx.sv
// ili9341_spi_rx: ILI9341 SPI monitor decoding CASET/PASET/RAMWR into pixel writes.
// Optional ILI_RX_SYNC_EN selects synchronised SPI inputs inside spi_byte_rx.
module ili9341_spi_rx
  import ili9341_pkg::*;
#(
  parameter int COORD_W = 9,
  parameter int COLS    = 240,
  parameter int ROWS    = 320
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sck,
  input  logic               spi_cs,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_data,
  output logic               frame_start,
  output logic               err_abort
);
  localparam logic [COORD_W-1:0] EC_DEF = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] EP_DEF = COORD_W'(ROWS - 1);
  state_t state, state_n;
  logic cs_rise, cmd, dat, ph;
  logic [2:0] pcnt;
  logic [7:0] hold;
  logic [COORD_W-1:0] sc, ec, sp, ep, x, y, pair;
  spi_byte_rx u_rx (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .cs_rise(cs_rise), .err_abort(err_abort)
  );
  assign cmd  = byte_valid & ~byte_dc;
  assign dat  = byte_valid & byte_dc;
  assign pair = COORD_W'({hold, byte_data});
  always_comb begin
    state_n = state;
    if (cmd)
      state_n = byte_data == CMD_CASET ? ST_CASET :
                byte_data == CMD_PASET ? ST_PASET :
                (byte_data == CMD_RAMWR || byte_data == CMD_RAMWRC) ? ST_RAMWR :
                byte_data == CMD_SWRESET ? ST_IDLE : ST_SKIP;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= 3'd0;
      ph          <= 1'b0;
      hold        <= 8'h00;
      sc          <= '0;
      ec          <= EC_DEF;
      sp          <= '0;
      ep          <= EP_DEF;
      x           <= '0;
      y           <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= 16'h0000;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (cmd) begin
        pcnt <= 3'd0;
        ph   <= 1'b0;
        if (byte_data == CMD_RAMWR) begin
          x           <= sc;
          y           <= sp;
          frame_start <= 1'b1;
        end
        if (byte_data == CMD_SWRESET) begin
          sc <= '0;
          ec <= EC_DEF;
          sp <= '0;
          ep <= EP_DEF;
          x  <= '0;
          y  <= '0;
        end
      end else if (dat && (state == ST_CASET || state == ST_PASET) && pcnt != 3'd4) begin
        pcnt <= pcnt + 3'd1;
        if (!pcnt[0]) hold <= byte_data;
        else if (state == ST_CASET) begin
          if (pcnt[1]) ec <= pair;
          else         sc <= pair;
        end else begin
          if (pcnt[1]) ep <= pair;
          else         sp <= pair;
        end
      end else if (dat && state == ST_RAMWR) begin
        ph <= ~ph;
        if (!ph) hold <= byte_data;
        else begin
          pix_valid <= 1'b1;
          pix_x     <= x;
          pix_y     <= y;
          pix_data  <= {hold, byte_data};
          if (x >= ec) begin
            x <= sc;
            y <= y >= ep ? sp : y + COORD_W'(1);
          end else x <= x + COORD_W'(1);
        end
      end
      if (cs_rise) ph <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ili9341_spi_rx.sv
// tb_ili9341_spi_rx: randomized bench checking ili9341_spi_rx against a byte-level model.
module tb_ili9341_spi_rx;
  localparam int CW = 9;
  localparam int MASK = (1 << CW) - 1;
  logic clk = 0, rst = 1, spi_sck = 0, spi_cs = 1, spi_mosi = 0, spi_dc = 0;
  logic byte_valid, byte_dc, pix_valid, frame_start, err_abort;
  logic [7:0] byte_data;
  logic [CW-1:0] pix_x, pix_y;
  logic [15:0] pix_data;
  ili9341_spi_rx #(.COORD_W(CW), .COLS(240), .ROWS(320)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .err_abort(err_abort)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int hp = 2;
  // reference model of the decoder at byte granularity; mode 0 = ignore data
  int m_mode, m_cnt, m_hold, m_have, m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  int exp_b[$], exp_px[$], exp_py[$], exp_pd[$];
  int log_x[$], log_y[$], log_d[$];
  int exp_fs = 0, exp_ab = 0, got_fs = 0, got_ab = 0, got_b = 0;
  int last_byte = 0, last_dc = 0;
  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_hold = 0; m_have = 0;
    m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319; m_x = 0; m_y = 0;
  endfunction
  function automatic void model_byte(int b, int dc);
    int v;
    exp_b.push_back(dc * 256 + b);
    if (dc == 0) begin
      m_cnt = 0; m_have = 0;
      case (b)
        'h2A: m_mode = 1;
        'h2B: m_mode = 2;
        'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; exp_fs++; end
        'h3C: m_mode = 3;
        'h01: model_reset();
        default: m_mode = 0;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_cnt < 4) begin
        if (m_cnt % 2 == 0) m_hold = b;
        else begin
          v = (m_hold * 256 + b) & MASK;
          if (m_mode == 1) begin if (m_cnt == 1) m_sc = v; else m_ec = v; end
          else begin if (m_cnt == 1) m_sp = v; else m_ep = v; end
        end
        m_cnt++;
      end
    end else if (m_mode == 3) begin
      if (m_have == 0) begin m_hold = b; m_have = 1; end
      else begin
        exp_px.push_back(m_x); exp_py.push_back(m_y); exp_pd.push_back(m_hold * 256 + b);
        m_have = 0;
        if (m_x >= m_ec) begin
          m_x = m_sc;
          m_y = (m_y >= m_ep) ? m_sp : ((m_y + 1) & MASK);
        end else m_x = (m_x + 1) & MASK;
      end
    end
  endfunction
  always @(negedge clk) begin
    if (byte_valid) begin
      got_b++; last_byte = int'(byte_data); last_dc = int'(byte_dc);
      if (exp_b.size() == 0) check("unexpected_byte", int'({byte_dc, byte_data}), -1);
      else check("byte", int'({byte_dc, byte_data}), exp_b.pop_front());
    end
    if (pix_valid) begin
      log_x.push_back(int'(pix_x)); log_y.push_back(int'(pix_y)); log_d.push_back(int'(pix_data));
      if (exp_px.size() == 0) check("unexpected_pixel", int'(pix_data), -1);
      else begin
        check("pix_x", int'(pix_x), exp_px.pop_front());
        check("pix_y", int'(pix_y), exp_py.pop_front());
        check("pix_data", int'(pix_data), exp_pd.pop_front());
      end
    end
    if (frame_start) got_fs++;
    if (err_abort) got_ab++;
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cs_low();
    if (spi_cs) begin spi_cs = 0; tick(hp); end
  endtask
  task automatic cs_high();
    tick(hp);
    spi_cs = 1;
    m_have = 0;
    tick(2 * hp);
  endtask
  task automatic send_bits(int b, int dc, int n);
    cs_low();
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i]; spi_dc = dc[0];
      tick(hp); spi_sck = 1; tick(hp); spi_sck = 0;
    end
  endtask
  task automatic send_byte(int b, int dc);
    model_byte(b, dc);
    send_bits(b, dc, 8);
  endtask
  task automatic send_pix(int d);
    send_byte(d >> 8, 1); send_byte(d & 255, 1);
  endtask
  task automatic check_pix(string name, int idx, int ex, int ey, int ed);
    check({name, "_x"}, log_x[idx], ex);
    check({name, "_y"}, log_y[idx], ey);
    check({name, "_d"}, log_d[idx], ed);
  endtask
  task automatic check_zero(string name);
    check({name, "_bytes"}, int'({byte_valid, byte_data, byte_dc}), 0);
    check({name, "_pix"}, int'({pix_valid, pix_x, pix_y, pix_data}), 0);
    check({name, "_pulses"}, int'({frame_start, err_abort}), 0);
  endtask
  int base, fs0, ab0, b0, k, np, s, e, cmdsel;
  int p[5];
  initial begin
    model_reset();
    tick(3);
    check_zero("reset");
    rst = 0;
    tick(2);
    // single byte at SCK = clk/8
    hp = 4;
    send_byte('hA5, 1); cs_high(); tick(4);
    check("single_data", last_byte, 'hA5);
    check("single_dc", last_dc, 1);
    check("single_count", got_b, 1);
    hp = 2;
    // cursor wrap in a 2x2 window
    base = log_x.size(); fs0 = got_fs;
    send_byte('h2A, 0); send_byte(0, 1); send_byte(10, 1); send_byte(0, 1); send_byte(11, 1);
    send_byte('h2B, 0); send_byte(0, 1); send_byte(5, 1); send_byte(0, 1); send_byte(6, 1);
    send_byte('h2C, 0);
    repeat (5) send_pix('hF800);
    cs_high(); tick(4);
    check("wrap_count", log_x.size() - base, 5);
    check_pix("wrap0", base, 10, 5, 'hF800);
    check_pix("wrap1", base + 1, 11, 5, 'hF800);
    check_pix("wrap2", base + 2, 10, 6, 'hF800);
    check_pix("wrap3", base + 3, 11, 6, 'hF800);
    check_pix("wrap4", base + 4, 10, 5, 'hF800);
    check("wrap_frame_start", got_fs - fs0, 1);
    // abort after 3 bits, then a clean RAMWRC
    ab0 = got_ab; b0 = got_b;
    send_bits('hFF, 1, 3); exp_ab++; cs_high(); tick(4);
    check("abort_pulse", got_ab - ab0, 1);
    check("abort_no_byte", got_b - b0, 0);
    send_byte('h3C, 0); cs_high(); tick(4);
    check("after_abort_byte", last_byte, 'h3C);
    check("after_abort_dc", last_dc, 0);
    // high byte discarded by CS toggle, cursor unchanged at (11,5)
    base = log_x.size();
    send_byte('hAB, 1); cs_high();
    send_byte('h12, 1); send_byte('h34, 1); cs_high(); tick(4);
    check("break_count", log_x.size() - base, 1);
    check_pix("break", base, 11, 5, 'h1234);
    // SWRESET defaults and 9-bit truncation
    base = log_x.size();
    send_byte('h01, 0); send_byte('h2C, 0);
    for (int i = 0; i < 241; i++) send_pix(int'($urandom_range(0, 65535)));
    cs_high(); tick(4);
    check("dflt_x239", log_x[base + 239], 239);
    check("dflt_y239", log_y[base + 239], 0);
    check("dflt_x240", log_x[base + 240], 0);
    check("dflt_y240", log_y[base + 240], 1);
    base = log_x.size();
    send_byte('h2A, 0); send_byte('h02, 1); send_byte('h05, 1); send_byte(0, 1); send_byte('h0A, 1);
    send_byte('h2B, 0); send_byte(0, 1); send_byte(0, 1); send_byte(0, 1); send_byte(3, 1);
    send_byte('h2C, 0); send_pix('h07E0); cs_high(); tick(4);
    check_pix("trunc", base, 5, 0, 'h07E0);
    // reset mid-RAMWR, mid-byte
    send_byte('h2C, 0); send_byte('h55, 1); send_bits('hF0, 1, 4);
    tick(2);
    rst = 1; tick(1);
    check_zero("midreset");
    rst = 0; model_reset();
    cs_high();
    base = log_x.size();
    send_byte('h11, 1); send_byte('h22, 1); cs_high(); tick(4);
    check("reset_ignores_data", log_x.size() - base, 0);
    check("reset_last_byte", last_byte, 'h22);
    // randomized command/data traffic
    for (int t = 0; t < 45; t++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2: begin
          s = int'($urandom_range(0, 20)); e = s + int'($urandom_range(0, 4));
          p[0] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : 0;
          p[1] = s; p[2] = 0; p[3] = e; p[4] = int'($urandom_range(0, 255));
          np = int'($urandom_range(1, 5));
          send_byte(k == 2 ? 'h2B : 'h2A, 0);
          for (int i = 0; i < np; i++) send_byte(p[i], 1);
        end
        3, 4, 5: begin
          send_byte(k == 5 ? 'h3C : 'h2C, 0);
          np = int'($urandom_range(0, 17));
          for (int i = 0; i < np; i++) send_byte(int'($urandom_range(0, 255)), 1);
        end
        6: cs_high();
        7: begin send_bits(int'($urandom_range(0, 255)), 1, int'($urandom_range(1, 7))); exp_ab++; cs_high(); end
        8: begin
          cmdsel = int'($urandom_range(0, 2));
          send_byte(cmdsel == 0 ? 'h01 : 'h36, 0);
          send_byte(int'($urandom_range(0, 255)), 1);
        end
        default: begin
          np = int'($urandom_range(1, 3));
          for (int i = 0; i < np; i++) send_byte(int'($urandom_range(0, 255)), 1);
        end
      endcase
    end
    cs_high(); tick(10);
    check("bytes_drained", exp_b.size(), 0);
    check("pixels_drained", exp_px.size(), 0);
    check("frame_start_total", got_fs, exp_fs);
    check("err_abort_total", got_ab, exp_ab);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
